prog_sequence_counter: RTL and testbench
========================================

PROG_SEQUENCE_COUNTER -- requirements
Module: prog_sequence_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 3: bit width of each sequence value.
REQ-002 SHALL have parameter DEPTH, default 8: number of table entries; legal range 2..256.
REQ-003 SHALL have parameter AW, default 3: table index width; SHALL equal ceil(log2(DEPTH)).
REQ-004 SHALL have port clock, input, 1: single clock; all state SHALL update on the falling edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: advance sequence by one step at this edge.
REQ-007 SHALL have port dir, input, 1: 0 = forward (index increments), 1 = reverse (index decrements).
REQ-008 SHALL have port wr_en, input, 1: write table entry.
REQ-009 SHALL have port wr_addr, input, AW: table entry to write.
REQ-010 SHALL have port wr_data, input, WIDTH: value to write.
REQ-011 SHALL have port len_we, input, 1: load last-index register.
REQ-012 SHALL have port len_data, input, AW: new last index (sequence length minus 1).
REQ-013 SHALL have port OUTPUT, output, WIDTH: registered current sequence value.
REQ-014 SHALL have port index, output, AW: registered current table index.
REQ-015 SHALL have port wrap, output, 1: registered one-cycle pulse on sequence wrap.

Function
REQ-016 SHALL hold a DEPTH x WIDTH table, a last-index register LAST, and index register IDX.
REQ-017 OUTPUT SHALL always equal table[IDX] as of the previous falling edge (registered, zero extra latency after IDX update).
REQ-018 en=1, dir=0: IDX SHALL become 0 if IDX==LAST, else IDX+1.
REQ-019 en=1, dir=1: IDX SHALL become LAST if IDX==0, else IDX-1.
REQ-020 wrap SHALL be 1 for exactly the cycle following a step where IDX went LAST->0 (forward) or 0->LAST (reverse); 0 otherwise.
REQ-021 en=0: IDX and OUTPUT SHALL hold; wrap SHALL be 0.
REQ-022 wr_en=1 SHALL write wr_data to table[wr_addr] at the edge; wr_addr >= DEPTH SHALL be ignored.
REQ-023 If the written entry equals the next IDX at the same edge, OUTPUT SHALL take wr_data (write-through).
REQ-024 len_we=1 SHALL load LAST with min(len_data, DEPTH-1), force IDX to 0, OUTPUT to table[0] (with write-through per REQ-023), wrap to 0.
REQ-025 len_we SHALL take priority over en at the same edge; en is ignored that edge.
REQ-026 len_data=0 SHALL give a length-1 sequence: IDX stays 0 and wrap pulses on every enabled step.
REQ-027 Index arithmetic SHALL be modulo LAST+1, never wrapping through 2^AW.
REQ-028 Table contents SHALL be held unchanged by en, dir, len_we.

Reset
REQ-029 reset=1 SHALL immediately, independent of clock, set table[i] = i mod 2^WIDTH for all i.
REQ-030 reset SHALL set LAST=DEPTH-1, IDX=0, OUTPUT=0, wrap=0.
REQ-031 reset asserted mid-sequence SHALL override all other inputs; first step after deassertion SHALL go IDX 0->1 (forward).

Verification
REQ-032 Defaults, reset then en=1 dir=0 for 9 edges -> OUTPUT 1,2,3,4,5,6,7,0,1; wrap=1 only after the 0 appears.
REQ-033 Load table 0,1,2,3,6,5,7 at addr 0..6, len_we with len_data=6, en=1 -> OUTPUT 1,2,3,6,5,7,0,1 repeating; wrap on each return to 0.
REQ-034 With REQ-033 table at IDX=3, set dir=1 for 5 edges -> OUTPUT 2,1,0,7,5; wrap after the 7.
REQ-035 len_we len_data=2 and en=1 same edge at IDX=5 -> IDX=0, OUTPUT=table[0], wrap=0; then 3-entry loop 0,1,2.
REQ-036 wr_en to addr 4 value 2 while stepping IDX 3->4 -> OUTPUT=2 same cycle; len_data=9 on DEPTH=8 -> LAST=7.
REQ-037 Assert reset between edges at IDX=5 -> OUTPUT=0, index=0, wrap=0 before next edge; table back to identity.

Source files
------------

// File: rtl/prog_sequence_counter.sv
// prog_sequence_counter
//   Programmable sequence generator. A DEPTH x WIDTH table holds the sequence
//   values. An index register walks the table forwards or backwards, modulo a
//   loadable last index. All state changes on the falling clock edge.
//
// Ports
//   clock    : in  1     single clock, active on the falling edge
//   reset    : in  1     asynchronous active-high reset
//   en       : in  1     step the index by one at this edge
//   dir      : in  1     0 = forward (increment), 1 = reverse (decrement)
//   wr_en    : in  1     write wr_data into table[wr_addr]
//   wr_addr  : in  AW    table entry to write (>= DEPTH ignored)
//   wr_data  : in  WIDTH value to write
//   len_we   : in  1     load last index (clamped to DEPTH-1), restart at 0
//   len_data : in  AW    new last index (sequence length minus 1)
//   OUTPUT   : out WIDTH registered table[index]
//   index    : out AW    registered current table index
//   wrap     : out 1     registered one-cycle pulse after a wrapping step
module prog_sequence_counter #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             len_we,
  input  logic [AW-1:0]    len_data,
  output logic [WIDTH-1:0] OUTPUT,
  output logic [AW-1:0]    index,
  output logic             wrap
);

  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_table [DEPTH];
  logic [AW-1:0]    r_last;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_out;
  logic             r_wrap;

  logic             w_addr_ok;
  logic [AW-1:0]    w_len_clamp;
  logic [AW-1:0]    w_idx_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_out_nxt;

  always_comb begin
    w_addr_ok   = (32'(wr_addr) < 32'(DEPTH));
    w_len_clamp = (32'(len_data) > 32'(DEPTH - 1)) ? LAST_MAX : len_data;

    w_idx_nxt  = r_idx;
    w_wrap_nxt = 1'b0;
    if (len_we) begin
      // Length load restarts the sequence and swallows any step this edge.
      w_idx_nxt = '0;
    end else if (en) begin
      if (!dir) begin
        if (r_idx == r_last) begin
          w_idx_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end else begin
        if (r_idx == '0) begin
          w_idx_nxt  = r_last;
          w_wrap_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx - 1'b1;
        end
      end
    end

    // Write-through: a write landing on the entry being selected this edge
    // must appear on OUTPUT now, not one step later.
    if (wr_en && w_addr_ok && (wr_addr == w_idx_nxt)) begin
      w_out_nxt = wr_data;
    end else begin
      w_out_nxt = r_table[w_idx_nxt];
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_table[i] <= WIDTH'(i);
      end
      r_last <= LAST_MAX;
      r_idx  <= '0;
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (wr_en && w_addr_ok) begin
        r_table[wr_addr] <= wr_data;
      end
      if (len_we) begin
        r_last <= w_len_clamp;
      end
      r_idx  <= w_idx_nxt;
      r_out  <= w_out_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign OUTPUT = r_out;
  assign index  = r_idx;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_prog_sequence_counter.sv
module tb_prog_sequence_counter;

  logic       clock = 1'b1;
  logic       reset;
  logic       en, dir, wr_en, len_we;
  logic [2:0] wr_addr, wr_data, len_data;
  logic [2:0] out_v, idx_v;
  logic       wrap_v;

  // Second instance: DEPTH not a power of two, for the length clamp.
  logic       b_en, b_dir, b_wr_en, b_len_we;
  logic [2:0] b_wr_addr, b_wr_data, b_len_data;
  logic [2:0] b_out, b_idx;
  logic       b_wrap;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  prog_sequence_counter dut (
    .clock(clock), .reset(reset), .en(en), .dir(dir),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_we(len_we), .len_data(len_data),
    .OUTPUT(out_v), .index(idx_v), .wrap(wrap_v)
  );

  prog_sequence_counter #(.WIDTH(3), .DEPTH(6), .AW(3)) dut6 (
    .clock(clock), .reset(reset), .en(b_en), .dir(b_dir),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .len_we(b_len_we), .len_data(b_len_data),
    .OUTPUT(b_out), .index(b_idx), .wrap(b_wrap)
  );

  typedef struct {
    logic       en, dir, wr_en;
    logic [2:0] wa, wd;
    logic       lw;
    logic [2:0] ld;
    logic [2:0] e_out, e_idx;
    logic       e_wrap;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic e, input logic d, input logic we,
                     input int wa, input int wd, input logic lw, input int ld,
                     input int eo, input int ei, input logic ew);
    vec_t v;
    v.en = e; v.dir = d; v.wr_en = we;
    v.wa = 3'(wa); v.wd = 3'(wd); v.lw = lw; v.ld = 3'(ld);
    v.e_out = 3'(eo); v.e_idx = 3'(ei); v.e_wrap = ew;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk3(input string tag, input int eo, input int ei, input int ew);
    chk({tag, ".OUTPUT"}, int'(out_v), eo);
    chk({tag, ".index"},  int'(idx_v), ei);
    chk({tag, ".wrap"},   int'(wrap_v), ew);
  endtask

  // Advance past the next falling (active) edge and sample 1 time unit later.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; dir = 0; wr_en = 0; wr_addr = 0; wr_data = 0; len_we = 0; len_data = 0;
  endtask

  int seq33 [7] = '{0, 1, 2, 3, 6, 5, 7};

  initial begin
    idle_inputs();
    b_en = 0; b_dir = 0; b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;
    b_len_we = 0; b_len_data = 0;
    reset = 1'b1;
    #12;
    chk3("reset", 0, 0, 0);
    reset = 1'b0;
    step();

    // Identity table, forward over the wrap.
    for (int k = 1; k <= 9; k++) add(1, 0, 0, 0, 0, 0, 0, k % 8, k % 8, (k % 8) == 0);
    // Reprogram entries 0..6 while holding at index 1.
    for (int a = 0; a < 7; a++) add(0, 0, 1, a, seq33[a], 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    // 7-entry loop, through the wrap, to index 3.
    for (int k = 1; k <= 10; k++) add(1, 0, 0, 0, 0, 0, 0, seq33[k % 7], k % 7, (k % 7) == 0);
    // Reverse from 3 through the wrap to LAST.
    add(1, 1, 0, 0, 0, 0, 0, 2, 2, 0);
    add(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 7, 6, 1);
    add(1, 1, 0, 0, 0, 0, 0, 5, 5, 0);
    // Length load beats en at the same edge; then 3-entry loop.
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    // Full length, write-through on the 3->4 step.
    add(0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3, 3, 0);
    add(1, 0, 1, 4, 2, 0, 0, 2, 4, 0);
    add(1, 0, 0, 0, 0, 0, 0, 5, 5, 0);
    // Write to a non-selected entry: no effect on OUTPUT now, seen later.
    add(1, 0, 1, 0, 4, 0, 0, 7, 6, 0);
    add(1, 0, 0, 0, 0, 0, 0, 7, 7, 0);
    // Write-through while holding.
    add(0, 0, 1, 7, 6, 0, 0, 6, 7, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 6, 7, 1);
    // Length 1: stays at 0, wraps on every enabled step.
    add(0, 0, 0, 0, 0, 1, 0, 4, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 4, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 4, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 4, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
    // Length load with simultaneous write to entry 0 (write-through).
    add(0, 0, 1, 0, 3, 1, 7, 3, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3, 3, 0);
    add(1, 0, 0, 0, 0, 0, 0, 2, 4, 0);
    add(1, 0, 0, 0, 0, 0, 0, 5, 5, 0);

    foreach (vq[i]) begin
      en = vq[i].en; dir = vq[i].dir; wr_en = vq[i].wr_en;
      wr_addr = vq[i].wa; wr_data = vq[i].wd;
      len_we = vq[i].lw; len_data = vq[i].ld;
      step();
      chk3($sformatf("vec%0d", i), vq[i].e_out, vq[i].e_idx, vq[i].e_wrap);
    end
    idle_inputs();

    // Asynchronous reset between edges at index 5.
    #2;
    reset = 1'b1;
    #1;
    chk3("async_reset", 0, 0, 0);
    en = 1;
    step();
    chk3("reset_holds", 0, 0, 0);
    reset = 1'b0;
    // Table back to identity, LAST back to 7.
    for (int k = 1; k <= 8; k++) begin
      step();
      chk3($sformatf("post_reset%0d", k), k % 8, k % 8, int'(k == 8));
    end
    en = 0;

    // DEPTH=6 instance: len_data=7 clamps to LAST=5.
    b_len_we = 1; b_len_data = 3'd7;
    step();
    b_len_we = 0;
    chk("d6.load.index", int'(b_idx), 0);
    b_en = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("d6.fwd%0d.index", k), int'(b_idx), k % 6);
      chk($sformatf("d6.fwd%0d.OUTPUT", k), int'(b_out), k % 6);
      chk($sformatf("d6.fwd%0d.wrap", k), int'(b_wrap), int'(k == 6));
    end
    b_dir = 1;
    step();
    chk("d6.rev.index", int'(b_idx), 5);
    chk("d6.rev.wrap", int'(b_wrap), 1);
    b_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
